// File: rtl/pcie_phy_pkg.sv
// Shared PHY definitions: K-symbol constants, link training state and bit-order helper.
package pcie_phy_pkg;

    localparam logic [7:0] COM_K = 8'hBC;
    localparam logic [7:0] IDL_K = 8'h7C;

    typedef enum logic {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } link_state_e;

    // Maps the serial position of a bit within a symbol to its index in the parallel word.
    function automatic int unsigned bit_index(input int unsigned pos,
                                              input int unsigned width,
                                              input bit          msb_first);
        return msb_first ? (width - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/bit_counter_wrap.sv
// Modulo-MODULUS up-counter with a wrap flag; resets to MODULUS-1 so the first edge wraps.
module bit_counter_wrap #(
    parameter int unsigned MODULUS = 8,
    parameter int unsigned CW      = $clog2(MODULUS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);

    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/paralelo_a_serial_param.sv
// Parallel-to-serial symbol serializer with COM training, IDLE fill and symbol markers.
module paralelo_a_serial_param
    import pcie_phy_pkg::*;
#(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  COM_SYM    = WIDTH'(COM_K),
    parameter logic [WIDTH-1:0]  IDLE_SYM   = WIDTH'(IDL_K),
    parameter int unsigned       TRAIN_SYMS = 4,
    parameter bit                MSB_FIRST  = 1'b1
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             active,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             out,
    output logic             sym_start,
    output logic             sym_is_data
);

    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned TCW = $clog2(TRAIN_SYMS + 1);

    logic [CW-1:0]    bit_cnt;
    logic             load;
    logic [CW-1:0]    idx;

    logic [WIDTH-1:0] sym_reg_q, sym_reg_d;
    logic             sym_flag_q, sym_flag_d;
    link_state_e      state_q, state_d;
    logic [TCW-1:0]   train_cnt_q, train_cnt_d;
    logic             out_q, out_d;
    logic             sym_start_q, sym_start_d;
    logic             sym_is_data_q, sym_is_data_d;

    bit_counter_wrap #(
        .MODULUS (WIDTH),
        .CW      (CW)
    ) u_bit_cnt (
        .clk_i  (clk32f),
        .rst_i  (reset),
        .cnt_o  (bit_cnt),
        .wrap_o (load)
    );

    always_comb begin
        sym_reg_d     = sym_reg_q;
        sym_flag_d    = sym_flag_q;
        state_d       = state_q;
        train_cnt_d   = train_cnt_q;
        idx           = CW'(bit_index(32'(bit_cnt), WIDTH, MSB_FIRST));
        out_d         = sym_reg_q[idx];
        sym_start_d   = (bit_cnt == '0);
        sym_is_data_d = sym_flag_q;
        ready_out     = load && (state_q == ACTIVE) && active;

        if (load) begin
            if (!active || state_q == TRAIN) begin
                sym_reg_d  = COM_SYM;
                sym_flag_d = 1'b0;
            end else if (valid_in) begin
                sym_reg_d  = data_in;
                sym_flag_d = 1'b1;
            end else begin
                sym_reg_d  = IDLE_SYM;
                sym_flag_d = 1'b0;
            end
        end

        // Deactivation is sampled on every edge; the symbol in sym_reg still drains normally.
        if (!active) begin
            state_d     = TRAIN;
            train_cnt_d = '0;
        end else if (state_q == TRAIN && load) begin
            train_cnt_d = train_cnt_q + TCW'(1);
            if (train_cnt_q == TCW'(TRAIN_SYMS - 1)) begin
                state_d = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            sym_reg_q     <= '0;
            sym_flag_q    <= 1'b0;
            state_q       <= TRAIN;
            train_cnt_q   <= '0;
            out_q         <= 1'b0;
            sym_start_q   <= 1'b0;
            sym_is_data_q <= 1'b0;
        end else begin
            sym_reg_q     <= sym_reg_d;
            sym_flag_q    <= sym_flag_d;
            state_q       <= state_d;
            train_cnt_q   <= train_cnt_d;
            out_q         <= out_d;
            sym_start_q   <= sym_start_d;
            sym_is_data_q <= sym_is_data_d;
        end
    end

    assign out         = out_q;
    assign sym_start   = sym_start_q;
    assign sym_is_data = sym_is_data_q;

endmodule

// File: tb/tb_paralelo_a_serial_param.sv
// Directed bench: expected serial bits are queued per symbol and compared as they emerge.
module tb_paralelo_a_serial_param;

    typedef struct packed {
        logic b;
        logic st;
        logic d;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset8 = 1'b1, active8 = 1'b1, valid8 = 1'b0;
    logic [7:0] data8 = '0;
    logic       ready8, out8, start8, isdata8;

    logic       reset10 = 1'b1, active10 = 1'b1, valid10 = 1'b0;
    logic [9:0] data10 = '0;
    logic       ready10, out10, start10, isdata10;

    int tests = 0;
    int fails = 0;
    exp_t expq[$];

    paralelo_a_serial_param dut8 (
        .clk32f      (clk),
        .reset       (reset8),
        .active      (active8),
        .data_in     (data8),
        .valid_in    (valid8),
        .ready_out   (ready8),
        .out         (out8),
        .sym_start   (start8),
        .sym_is_data (isdata8)
    );

    paralelo_a_serial_param #(
        .WIDTH      (10),
        .COM_SYM    (10'h17C),
        .IDLE_SYM   (10'h07C),
        .TRAIN_SYMS (1),
        .MSB_FIRST  (1'b0)
    ) dut10 (
        .clk32f      (clk),
        .reset       (reset10),
        .active      (active10),
        .data_in     (data10),
        .valid_in    (valid10),
        .ready_out   (ready10),
        .out         (out10),
        .sym_start   (start10),
        .sym_is_data (isdata10)
    );

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input bit sel);
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("out",         {9'b0, sel ? out10    : out8},    {9'b0, e.b});
            check("sym_start",   {9'b0, sel ? start10  : start8},  {9'b0, e.st});
            check("sym_is_data", {9'b0, sel ? isdata10 : isdata8}, {9'b0, e.d});
        end
    endtask

    task automatic push_sym(input bit sel, input logic [9:0] s, input bit d);
        int unsigned w = sel ? 10 : 8;
        exp_t e;
        for (int unsigned i = 0; i < w; i++) begin
            e.b  = sel ? s[i] : s[w-1-i];
            e.st = (i == 0);
            e.d  = d;
            expq.push_back(e);
        end
    endtask

    // One full symbol window; ready is checked mid-window and just before the load edge.
    task automatic sym(input bit sel, input logic [9:0] s, input bit d,
                       input bit rdy_end, input int drop_at);
        int unsigned w = sel ? 10 : 8;
        push_sym(sel, s, d);
        for (int i = 0; i < int'(w); i++) begin
            if (i == drop_at) active8 = 1'b0;
            if (i == 1) check("ready_mid", {9'b0, sel ? ready10 : ready8}, 10'd0);
            if (i == int'(w) - 1) check("ready_load", {9'b0, sel ? ready10 : ready8}, {9'b0, rdy_end});
            tick(sel);
        end
    endtask

    task automatic release_reset(input bit sel);
        exp_t e;
        @(negedge clk);
        if (sel) reset10 = 1'b0; else reset8 = 1'b0;
        check("ready_first", {9'b0, sel ? ready10 : ready8}, 10'd0);
        e = '0;
        expq.push_back(e);
        tick(sel);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out",   {9'b0, out8},    10'd0);
        check("rst_start", {9'b0, start8},  10'd0);
        check("rst_data",  {9'b0, isdata8}, 10'd0);
        check("rst_ready", {9'b0, ready8},  10'd0);

        // Training with a word already offered: it must wait for the first ready load.
        release_reset(1'b0);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        valid8 = 1'b1;
        data8  = 8'hA5;
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b1, -1);
        valid8 = 1'b0;
        sym(1'b0, 10'hA5, 1'b1, 1'b1, -1);
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);

        // Back-to-back words.
        valid8 = 1'b1;
        data8  = 8'h01;
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);
        data8  = 8'h80;
        sym(1'b0, 10'h01, 1'b1, 1'b1, -1);
        data8  = 8'hFF;
        sym(1'b0, 10'h80, 1'b1, 1'b1, -1);
        valid8 = 1'b0;
        sym(1'b0, 10'hFF, 1'b1, 1'b1, -1);
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);

        // Link drop mid-word, then retraining.
        valid8 = 1'b1;
        data8  = 8'h3C;
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);
        valid8 = 1'b0;
        sym(1'b0, 10'h3C, 1'b1, 1'b0, 3);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        active8 = 1'b1;
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b1, -1);
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);

        // Async reset inside a data symbol.
        valid8 = 1'b1;
        data8  = 8'h5A;
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);
        valid8 = 1'b0;
        push_sym(1'b0, 10'h5A, 1'b1);
        repeat (3) tick(1'b0);
        #2 reset8 = 1'b1;
        #1;
        check("abort_out",   {9'b0, out8},    10'd0);
        check("abort_start", {9'b0, start8},  10'd0);
        check("abort_data",  {9'b0, isdata8}, 10'd0);
        check("abort_ready", {9'b0, ready8},  10'd0);
        expq.delete();
        @(negedge clk);
        release_reset(1'b0);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b0, -1);
        sym(1'b0, 10'hBC, 1'b0, 1'b1, -1);
        sym(1'b0, 10'h7C, 1'b0, 1'b1, -1);

        // 10-bit LSB-first instance with a single training symbol.
        check("rst10_out",   {9'b0, out10},   10'd0);
        check("rst10_ready", {9'b0, ready10}, 10'd0);
        valid10 = 1'b1;
        data10  = 10'h2B5;
        release_reset(1'b1);
        sym(1'b1, 10'h17C, 1'b0, 1'b1, -1);
        valid10 = 1'b0;
        sym(1'b1, 10'h2B5, 1'b1, 1'b1, -1);
        sym(1'b1, 10'h07C, 1'b0, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/paralelo_a_serial_param.md
Name: paralelo_a_serial_param

Overview:
- Parametrised parallel-to-serial symbol serializer for the PCIe-style physical-layer transmit path, running on the fast serial clock (clk32f domain).
- Serializes WIDTH-bit data words with a valid/ready handshake.
- Inserts symbols automatically: COM training symbols after reset or link deactivation, and IDLE fill symbols when the link is active but no data is offered.
- Emits a symbol-boundary marker and a data/control flag so downstream serial logic and checkers can align to symbols.

Parameters:
- WIDTH, 8: symbol width in bits, ≥2.
- COM_SYM, 8'hBC: COM/training symbol, WIDTH bits.
- IDLE_SYM, 8'h7C: fill symbol sent when active and no valid data, WIDTH bits.
- TRAIN_SYMS, 4: number of consecutive COM symbols sent before data is accepted, ≥1.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 first.

Ports:
- clk32f, input, 1: serial bit clock; one output bit per rising edge.
- reset, input, 1: asynchronous, active-high reset.
- active, input, 1: link enable. When 0, only COM is sent and the block re-enters training.
- data_in, input, WIDTH: parallel word to serialize.
- valid_in, input, 1: data_in is valid.
- ready_out, output, 1: block accepts data_in on this edge if valid_in=1.
- out, output, 1: registered serial bit.
- sym_start, output, 1: registered; 1 while out carries the first bit of a symbol.
- sym_is_data, output, 1: registered; 1 for every bit of a symbol that came from data_in.

Behaviour:
- Reset (asynchronous, while reset=1):
  - out=0, sym_start=0, sym_is_data=0.
  - bit_cnt=WIDTH-1, sym_reg=0, state=TRAIN, train_cnt=0.
  - Reset mid-symbol aborts the symbol immediately; no partial-word recovery.
- bit_cnt (width $clog2(WIDTH)) increments each edge and wraps WIDTH-1→0. A load edge is an edge where bit_cnt==WIDTH-1.
- On every edge:
  - out <= sym_reg[bit index of bit_cnt], mapped through MSB_FIRST.
  - sym_start <= (bit_cnt==0).
  - sym_is_data holds the flag of the symbol currently in sym_reg.
- On a load edge, sym_reg is loaded with the next symbol and bit_cnt <= 0. Next-symbol priority:
  1. active=0 → COM_SYM.
  2. state=TRAIN → COM_SYM.
  3. valid_in=1 → data_in, with data flag = 1.
  4. Otherwise → IDLE_SYM.
- ready_out is combinational: ready_out = (bit_cnt==WIDTH-1) && state==ACTIVE && active.
  - A word is consumed only when valid_in && ready_out.
  - Upstream holds data_in and valid_in until accepted.
  - valid_in while ready_out=0 is ignored and the word is not lost.
- Latency:
  - Word accepted at edge t → MSB (or LSB) appears on out after edge t+1.
  - Last bit appears after edge t+WIDTH.
  - Back-to-back accepted words produce a gapless stream.
- State machine:
  - TRAIN: each COM load increments train_cnt. When a load makes train_cnt reach TRAIN_SYMS and active=1, the state moves to ACTIVE. The next load can then take data.
  - ACTIVE: stays while active=1.
  - Leaving ACTIVE: active=0 sampled on any edge → state=TRAIN, train_cnt=0. The symbol already in flight completes untouched.
  - active=0 during TRAIN: train_cnt holds at 0; COM continues.
- The first symbol after reset starts after the first edge following reset release. That first out bit is 0 from the reset sym_reg, and sym_start=1 on the next edge.
- An async reset assertion coinciding with a load edge: reset wins.

Decomposition:
- Shared package pcie_phy_pkg: K-symbol constants COM_K=8'hBC and IDL_K=8'h7C; state enum {TRAIN, ACTIVE}; a bit-order helper function.
- No sub-module is required. Optionally split out a bit_counter_wrap sub-module (modulo-WIDTH counter with a wrap flag), which is shareable with the serial_to_parallel receiver.

Test Plan:
- Reset release with active=1, valid_in=0, WIDTH=8, TRAIN_SYMS=4 → 4 × BC (10111100) on out, then continuous 7C (01111100). sym_start every 8 cycles. ready_out low until the 4th COM is loaded.
- After training, valid_in=1 with data_in=8'hA5 held → accepted on the first ready edge. out shows 10100101 starting 1 cycle later, sym_is_data=1 for exactly 8 bits, then 7C.
- Three back-to-back words 8'h01, 8'h80, 8'hFF with valid_in held → 24 contiguous bits, no IDLE between them, ready_out pulsed 3 times.
- active dropped mid-data-symbol → current word completes, then BC symbols. Re-asserting active → 4 BC symbols before ready_out returns.
- Async reset asserted at bit 3 of a data symbol → out=0 immediately. The word is not retransmitted, and the training sequence restarts.
- Instance with WIDTH=10, MSB_FIRST=0, COM_SYM=10'h17C, TRAIN_SYMS=1 → LSB-first output, 10-cycle symbol period, single COM before data.
